ripple_borrow_subtractor_seq: RTL and testbench
===============================================

Name: ripple_borrow_subtractor_seq

Overview:
- Multi-cycle ripple-borrow subtractor, the inverse arithmetic direction of the team's ripple-carry adder.
- Computes diff = a - b - bin and the borrow-out, processing CHUNK bits per clock through a chain of full-subtractor cells.
- Sits behind a valid/ready input port and a valid/ready output port.
- Intended for area-constrained datapaths where a full-width ripple chain misses timing.

Parameters:
- WIDTH, 28, operand and result width in bits.
- CHUNK, 4, bits resolved per RUN cycle. WIDTH % CHUNK must be 0; an elaboration-time error is raised otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (async assert, sync deassert at the clk edge):
  - state = IDLE, in_ready = 1, out_valid = 0, diff = 0, bout = 0.
  - Counter and operand registers are cleared.
- NCHUNK = WIDTH/CHUNK. The chunk counter is clog2(NCHUNK) bits, minimum 1.
- FSM:
  - IDLE: on in_valid && in_ready, capture a, b, bin into registers. Set the borrow register to bin, cnt = 0, diff = 0, and go to RUN. a, b and bin are sampled only at this edge.
  - RUN: each edge applies the CHUNK-cell chain to slice [cnt*CHUNK +: CHUNK] using a_r, b_r and the borrow register.
    - The resulting slice is written into diff, and the chain borrow-out is written into the borrow register.
    - When cnt == NCHUNK-1, bout is loaded with the final borrow and the FSM goes to DONE. Otherwise cnt increments.
  - DONE: out_valid = 1; diff and bout are held stable. On out_ready, go to IDLE.
- Latency:
  - out_valid rises exactly NCHUNK edges after the accept edge (7 for the defaults).
  - in_ready re-asserts the cycle after the output handshake.
  - Maximum throughput is one operation per NCHUNK+2 cycles. There is no overlap of operations.
- Backpressure: DONE holds indefinitely while out_ready = 0. in_valid is ignored outside IDLE and no operand is lost, because in_ready = 0.
- out_ready while not in DONE has no effect.
- diff is a registered output. Partial slices are visible during RUN, but diff is only defined while out_valid = 1.
- Full-subtractor cell equations: d = x ^ y ^ bi; bo = (~x & y) | (~(x ^ y) & bi).
- Boundary cases:
  - Borrow ripples across chunk boundaries via the borrow register.
  - When a == b and bin = 0: diff = 0, bout = 0.
  - When a = 0 and b = 0 with bin = 1: diff = all-ones, bout = 1.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. All outputs return to their reset values, with no result emitted.
- No combinational path from inputs to outputs. in_ready and out_valid are decoded from the state register only.

Decomposition:
- Shared package arith_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - helper function nchunk(WIDTH, CHUNK);
  - counter-width localparam derivation.
- One natural sub-module: fs, a 1-bit full subtractor (x, y, bi -> d, bo). It is instantiated CHUNK times in a generate loop to form the per-cycle chain.
- The FSM, counter and registers live in the top module.

Test Plan:
- a=0x000000A, b=0x0000003, bin=0, out_ready=1 -> out_valid exactly 7 edges after accept; diff=0x0000007, bout=0; in_ready=1 on the next cycle.
- a=0x0000000, b=0x0000001, bin=0 -> diff=0xFFFFFFF, bout=1 (borrow ripples through all 7 chunks). Repeat with a=0, b=0, bin=1 -> same result.
- a=0x8000000, b=0x0000000, bin=1 -> diff=0x7FFFFFF, bout=0. Then a=b=0x5A5A5A5, bin=0 -> diff=0, bout=0.
- Backpressure: hold out_ready=0 for 5 cycles after DONE, and drive in_valid=1 with new operands throughout. Required: diff/bout stable, out_valid=1, in_ready=0. After release, the next operation uses only operands presented in IDLE.
- Drop rst_n during RUN at cnt=3 -> out_valid=0, in_ready=1, diff=0, bout=0 asynchronously. A fresh operation (0x1234567 - 0x0000568 -> 0x1233FFF, bout=0) completes correctly.
- 2000 random operations with random in_valid/out_ready gaps, checked against a scoreboard model of {bout,diff} = {1'b0,a} - b - bin. Repeat with CHUNK=1 (latency 28), CHUNK=7 (latency 4) and CHUNK=28 (latency 1).

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared definitions for the sequential arithmetic blocks.
//   state_t   - control FSM states (IDLE / RUN / DONE)
//   nchunk    - number of CHUNK-wide slices in a WIDTH-bit operand
//   cnt_width - width of a slice counter for n slices (never below 1 bit)
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 28;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-slice configuration still needs a 1-bit counter register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_NCHUNK = nchunk(DEFAULT_WIDTH, DEFAULT_CHUNK);
  localparam int DEFAULT_CNT_W  = cnt_width(DEFAULT_NCHUNK);

endpackage

// File: rtl/fs.sv
// fs: 1-bit full subtractor cell, computes x - y - bi.
//   x  - minuend bit
//   y  - subtrahend bit
//   bi - borrow in from the next-lower bit
//   d  - difference bit
//   bo - borrow out to the next-higher bit
module fs (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  // Borrow when x is 0 and y is 1, or when x == y and a borrow arrives.
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/ripple_borrow_subtractor_seq.sv
// ripple_borrow_subtractor_seq: multi-cycle ripple-borrow subtractor.
// Computes diff = a - b - bin (mod 2^WIDTH) and bout = (a < b + bin),
// resolving CHUNK bits per clock through a chain of fs cells. The borrow
// between slices is carried in a register, so the combinational path is
// only CHUNK cells deep.
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - operands valid
//   in_ready  - block accepts operands (IDLE only)
//   a, b, bin - minuend, subtrahend, borrow-in (sampled on accept)
//   out_valid - result valid (DONE only)
//   out_ready - consumer takes the result
//   diff      - registered difference
//   bout      - registered borrow-out
module ripple_borrow_subtractor_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_chunk_check
      $error("ripple_borrow_subtractor_seq: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t             state_reg,  state_next;
  logic [CNT_W-1:0]   cnt_reg,    cnt_next;
  logic [WIDTH-1:0]   a_reg,      a_next;
  logic [WIDTH-1:0]   b_reg,      b_next;
  logic               borrow_reg, borrow_next;
  logic [WIDTH-1:0]   diff_reg,   diff_next;
  logic               bout_reg,   bout_next;

  logic [CHUNK-1:0]   a_slice;
  logic [CHUNK-1:0]   b_slice;
  logic [CHUNK-1:0]   d_slice;
  logic [CHUNK:0]     chain;

  // Operand slice for the current counter value; constant-index mux keeps
  // every select in range for any WIDTH/CHUNK pairing.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        a_slice = a_reg[i*CHUNK +: CHUNK];
        b_slice = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  // Per-cycle borrow chain, seeded from the borrow register.
  assign chain[0] = borrow_reg;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
      fs u_fs (
        .x  (a_slice[gi]),
        .y  (b_slice[gi]),
        .bi (chain[gi]),
        .d  (d_slice[gi]),
        .bo (chain[gi+1])
      );
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    borrow_next = borrow_reg;
    diff_next   = diff_reg;
    bout_next   = bout_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next      = a;
          b_next      = b;
          borrow_next = bin;
          cnt_next    = '0;
          diff_next   = '0;
          state_next  = RUN;
        end
      end

      RUN: begin
        borrow_next = chain[CHUNK];
        for (int i = 0; i < NCHUNK; i++) begin
          if (cnt_reg == CNT_W'(i)) begin
            diff_next[i*CHUNK +: CHUNK] = d_slice;
          end
        end
        if (cnt_reg == LAST_CNT) begin
          bout_next  = chain[CHUNK];
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      borrow_reg <= borrow_next;
      diff_reg   <= diff_next;
      bout_reg   <= bout_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign diff      = diff_reg;
  assign bout      = bout_reg;

endmodule

// File: tb/tb_ripple_borrow_subtractor_seq.sv
module tb_ripple_borrow_subtractor_seq;

  localparam int W   = 28;
  localparam int NCH = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  wire          in_ready;
  wire          out_valid;
  wire  [W-1:0] diff;
  wire          bout;

  // Alternate-CHUNK instances: index 0 -> CHUNK 1, 1 -> CHUNK 7, 2 -> CHUNK 28.
  logic [2:0]   alt_in_valid;
  logic [2:0]   alt_out_ready;
  wire  [2:0]   alt_in_ready;
  wire  [2:0]   alt_out_valid;
  wire  [2:0]   alt_bout;
  logic [W-1:0] alt_diff [3];

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  ripple_borrow_subtractor_seq #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_alt
      ripple_borrow_subtractor_seq #(
        .WIDTH (W),
        .CHUNK ((gi == 0) ? 1 : ((gi == 1) ? 7 : 28))
      ) u_alt (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (alt_in_valid[gi]),
        .in_ready  (alt_in_ready[gi]),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (alt_out_valid[gi]),
        .out_ready (alt_out_ready[gi]),
        .diff      (alt_diff[gi]),
        .bout      (alt_bout[gi])
      );
    end
  endgenerate

  function automatic int alt_latency(input int k);
    return (k == 0) ? 28 : ((k == 1) ? 4 : 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands and wait for the accept edge; returns at the falling
  // edge just after the accept.
  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ibin, input string tag);
    int n;
    a = ia; b = ib; bin = ibin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic finish_op(input int hold, input string tag);
    out_ready = 1'b0;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                    input logic [W-1:0] exp_d, input logic exp_bo,
                    input int hold, input string tag);
    start_op(ia, ib, ibin, tag);
    wait_done(NCH, tag);
    check({tag, "_diff"}, 32'(diff), 32'(exp_d));
    check({tag, "_bout"}, 32'(bout), 32'(exp_bo));
    $display("op %s a=%07h b=%07h bin=%0d -> diff=%07h bout=%0d", tag, ia, ib, ibin, diff, bout);
    finish_op(hold, tag);
  endtask

  task automatic alt_op(input int k, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin);
    logic [W:0] model;
    int n;
    int lat;
    model = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, ibin};
    a = ia; b = ib; bin = ibin; alt_in_valid[k] = 1'b1;
    n = 0;
    while (!alt_in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("alt%0d_accept_ready", k), 32'(alt_in_ready[k]), 32'd1);
    @(negedge clk);
    alt_in_valid[k] = 1'b0;
    lat = 0;
    while (!alt_out_valid[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("alt%0d_latency", k), 32'(lat), 32'(alt_latency(k)));
    check($sformatf("alt%0d_diff", k), 32'(alt_diff[k]), 32'(model[W-1:0]));
    check($sformatf("alt%0d_bout", k), 32'(alt_bout[k]), 32'(model[W]));
    $display("alt%0d a=%07h b=%07h bin=%0d -> diff=%07h bout=%0d", k, ia, ib, ibin,
             alt_diff[k], alt_bout[k]);
    alt_out_ready[k] = 1'b1;
    @(negedge clk);
    alt_out_ready[k] = 1'b0;
    check($sformatf("alt%0d_in_ready_after", k), 32'(alt_in_ready[k]), 32'd1);
  endtask

  function automatic logic [W-1:0] rand_word(input int mode, input logic [W-1:0] other);
    logic [W-1:0] v;
    v = W'($urandom());
    case (mode)
      1: v = other;
      2: v = '0;
      3: v = '1;
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;
    logic [W:0]   model;
    int           lat;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    alt_in_valid = '0;
    alt_out_ready = '0;

    // Reset state
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    out_ready = 1'b1;
    op(28'h000000A, 28'h0000003, 1'b0, 28'h0000007, 1'b0, 0, "basic");
    op(28'h0000000, 28'h0000001, 1'b0, 28'hFFFFFFF, 1'b1, 1, "zero_minus_one");
    op(28'h0000000, 28'h0000000, 1'b1, 28'hFFFFFFF, 1'b1, 0, "zero_bin");
    op(28'h8000000, 28'h0000000, 1'b1, 28'h7FFFFFF, 1'b0, 2, "msb_bin");
    op(28'h5A5A5A5, 28'h5A5A5A5, 1'b0, 28'h0000000, 1'b0, 0, "equal");

    // Backpressure: hold the result while new operands are offered
    start_op(28'h0000100, 28'h0000001, 1'b0, "bp");
    wait_done(NCH, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 28'hFFFFFFF; b = 28'h0000001; bin = 1'b1;
      @(negedge clk);
      check("bp_hold_diff", 32'(diff), 32'h00000FF);
      check("bp_hold_bout", 32'(bout), 32'd0);
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    $display("op bp a=0000100 b=0000001 bin=0 -> diff=%07h bout=%0d (held 5 cycles)", diff, bout);
    in_valid = 1'b0;
    finish_op(0, "bp");
    op(28'h0000020, 28'h0000010, 1'b1, 28'h000000F, 1'b0, 0, "after_bp");

    // Reset in the middle of RUN (cnt = 3)
    start_op(28'hFFFFFFF, 28'h0000000, 1'b0, "rst_mid");
    repeat (3) @(negedge clk);
    check("rst_mid_partial_diff", 32'(diff), 32'h0000FFF);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_diff", 32'(diff), 32'd0);
    check("rst_mid_bout", 32'(bout), 32'd0);
    $display("op rst_mid aborted at cnt=3");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(28'h1234567, 28'h0000568, 1'b0, 28'h1233FFF, 1'b0, 0, "after_rst");

    // Random operations against the arithmetic model
    for (int i = 0; i < 2000; i++) begin
      ra = rand_word($urandom_range(0, 5), '0);
      rb = rand_word($urandom_range(0, 5), ra);
      rbin = 1'($urandom_range(0, 1));
      model = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op(ra, rb, rbin, model[W-1:0], model[W], $urandom_range(0, 3), "rand");
    end

    // Other chunk sizes
    for (int k = 0; k < 3; k++) begin
      alt_op(k, 28'h0000000, 28'h0000001, 1'b0);
      alt_op(k, 28'h1234567, 28'h0000568, 1'b0);
      for (int i = 0; i < 40; i++) begin
        ra = rand_word($urandom_range(0, 5), '0);
        rb = rand_word($urandom_range(0, 5), ra);
        rbin = 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        alt_op(k, ra, rb, rbin);
      end
    end

    lat = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
